// File: rtl/pipe_flopenr_pkg.sv
// Shared definitions for the pipe_flopenr elastic pipeline register.
//   occ_width(depth) : width of the occupancy count for a pipeline of
//                      'depth' stages (holds 0..depth).
//   PIPE_WIDTH_DEF / PIPE_DEPTH_DEF : default payload width and stage count.
package pipe_flopenr_pkg;

    localparam int PIPE_WIDTH_DEF = 32;
    localparam int PIPE_DEPTH_DEF = 2;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_flopenr_stage.sv
// One valid+data stage of the elastic pipeline.
// Ports:
//   clk, reset (async, active low), flush (sync squash of the valid bit)
//   adv      : this stage may take a new value this edge
//   src_vld  : valid of the upstream source
//   src_dat  : payload of the upstream source
//   vld, dat : stage state
module pipe_flopenr_stage
    import pipe_flopenr_pkg::*;
#(
    parameter int               WIDTH     = PIPE_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             adv,
    input  logic             src_vld,
    input  logic [WIDTH-1:0] src_dat,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= 1'b0;
            dat <= RESET_VAL;
        end else begin
            // Flush wins over advance and clears only the valid bit.
            if (flush)
                vld <= 1'b0;
            else if (adv)
                vld <= src_vld;
            // Bubbles never load, so the data bits stay quiet when idle.
            if (adv && src_vld && !flush)
                dat <= src_dat;
        end
    end

endmodule

// File: rtl/pipe_flopenr.sv
// DEPTH-stage elastic pipeline register with valid/ready on both sides,
// bubble collapse and synchronous flush.
// Ports:
//   clk, reset (async, active low), flush (sync squash of all stages)
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake, stage DEPTH-1
//   occ                          : occupancy count, only when
//                                  PIPE_FLOPENR_OCC_EN is defined
module pipe_flopenr
    import pipe_flopenr_pkg::*;
#(
    parameter int               WIDTH     = PIPE_WIDTH_DEF,
    parameter int               DEPTH     = PIPE_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_FLOPENR_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occ
`endif
);

    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0][WIDTH-1:0] dat;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             s_vld;
        logic [WIDTH-1:0] s_dat;

        if (i == 0) begin : g_head
            assign s_vld = in_valid & in_ready;
            assign s_dat = in_data;
        end else begin : g_body
            assign s_vld = vld[i-1];
            assign s_dat = dat[i-1];
        end

        // Unrolled form of adv[i] = adv[i+1] | ~vld[i]: a stage stalls only
        // when it and every stage after it are full and the output is blocked.
        assign adv[i] = out_ready | ~(&vld[DEPTH-1:i]);

        pipe_flopenr_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .adv     (adv[i]),
            .src_vld (s_vld),
            .src_dat (s_dat),
            .vld     (vld[i]),
            .dat     (dat[i])
        );
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

`ifdef PIPE_FLOPENR_OCC_EN
    localparam int OW = occ_width(DEPTH);

    logic in_xfer, out_xfer;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            occ <= '0;
        else if (flush)
            occ <= '0;
        else begin
            case ({in_xfer, out_xfer})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_pipe_flopenr.sv
// Self-checking bench for pipe_flopenr: a DEPTH=2 and a DEPTH=3 instance,
// each with a queue scoreboard fed on input transfers and drained on output
// transfers, plus scenario tasks with direct checks.
module tb_pipe_flopenr;
    localparam int W = 32;
    localparam logic [W-1:0] RV2 = 32'hDEAD_BEEF;
    localparam logic [W-1:0] RV3 = 32'h1234_5678;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic fl2 = 0, iv2 = 0, ir2, ov2, or2 = 0;
    logic [W-1:0] id2 = '0, od2;
    logic fl3 = 0, iv3 = 0, ir3, ov3, or3 = 0;
    logic [W-1:0] id3 = '0, od3;
`ifdef PIPE_FLOPENR_OCC_EN
    logic [1:0] occ2, occ3;
`endif

    int total = 0;
    int bad = 0;
    int nout2 = 0;
    logic [W-1:0] q2[$];
    logic [W-1:0] q3[$];
    logic [W-1:0] e2, e3;

    pipe_flopenr #(.WIDTH(W), .DEPTH(2), .RESET_VAL(RV2)) u2 (
        .clk(clk), .reset(reset), .flush(fl2),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2)
`ifdef PIPE_FLOPENR_OCC_EN
        , .occ(occ2)
`endif
    );

    pipe_flopenr #(.WIDTH(W), .DEPTH(3), .RESET_VAL(RV3)) u3 (
        .clk(clk), .reset(reset), .flush(fl3),
        .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3)
`ifdef PIPE_FLOPENR_OCC_EN
        , .occ(occ3)
`endif
    );

    // Scoreboards: sample on the falling edge, the state the next rising
    // edge will act on.
    always @(negedge clk) begin
        if (reset) begin
`ifdef PIPE_FLOPENR_OCC_EN
            total++;
            if (occ2 !== 2'(q2.size())) begin
                bad++; $display("FAIL occ2_track got=%0d exp=%0d", occ2, q2.size());
            end
`endif
            if (ov2 && or2) begin
                total++; nout2++;
                if (q2.size() == 0) begin
                    bad++; $display("FAIL sb2_extra got=%h exp=none", od2);
                end else begin
                    e2 = q2.pop_front();
                    if (od2 !== e2) begin
                        bad++; $display("FAIL sb2_data got=%h exp=%h", od2, e2);
                    end
                end
            end
            if (fl2) q2.delete();
            else if (iv2 && ir2) q2.push_back(id2);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
`ifdef PIPE_FLOPENR_OCC_EN
            total++;
            if (occ3 !== 2'(q3.size())) begin
                bad++; $display("FAIL occ3_track got=%0d exp=%0d", occ3, q3.size());
            end
`endif
            if (ov3 && or3) begin
                total++;
                if (q3.size() == 0) begin
                    bad++; $display("FAIL sb3_extra got=%h exp=none", od3);
                end else begin
                    e3 = q3.pop_front();
                    if (od3 !== e3) begin
                        bad++; $display("FAIL sb3_data got=%h exp=%h", od3, e3);
                    end
                end
            end
            if (fl3) q3.delete();
            else if (iv3 && ir3) q3.push_back(id3);
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        total++; if (ov2 !== 1'b0)  begin bad++; $display("FAIL rst_ov2 got=%b exp=0", ov2); end
        total++; if (od2 !== RV2)   begin bad++; $display("FAIL rst_od2 got=%h exp=%h", od2, RV2); end
        total++; if (ov3 !== 1'b0)  begin bad++; $display("FAIL rst_ov3 got=%b exp=0", ov3); end
        total++; if (od3 !== RV3)   begin bad++; $display("FAIL rst_od3 got=%h exp=%h", od3, RV3); end
        @(posedge clk); #1 reset = 1'b1;
        // Hold two items, then drop reset mid-cycle.
        or2 = 0; iv2 = 1; id2 = 32'hC1; cyc();
        id2 = 32'hC2; cyc();
        iv2 = 0; #2;
        total++; if (ov2 !== 1'b1 || od2 !== 32'hC1) begin
            bad++; $display("FAIL held_head got=%b/%h exp=1/000000c1", ov2, od2);
        end
        #1 reset = 1'b0;
        #1;
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL midrst_ov got=%b exp=0", ov2); end
        total++; if (od2 !== RV2)  begin bad++; $display("FAIL midrst_od got=%h exp=%h", od2, RV2); end
`ifdef PIPE_FLOPENR_OCC_EN
        total++; if (occ2 !== 2'd0) begin bad++; $display("FAIL midrst_occ got=%0d exp=0", occ2); end
`endif
        q2.delete(); q3.delete();
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_stream();
        or2 = 1; iv2 = 1; id2 = 32'h11; #2;
        total++; if (ir2 !== 1'b1) begin bad++; $display("FAIL str_rdy0 got=%b exp=1", ir2); end
        cyc(); id2 = 32'h22; #2;
        total++; if (ir2 !== 1'b1) begin bad++; $display("FAIL str_rdy1 got=%b exp=1", ir2); end
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL str_lat got=%b exp=0", ov2); end
        cyc(); id2 = 32'h33; #2;
        total++; if (ir2 !== 1'b1) begin bad++; $display("FAIL str_rdy2 got=%b exp=1", ir2); end
        total++; if (ov2 !== 1'b1 || od2 !== 32'h11) begin bad++; $display("FAIL str_o11 got=%b/%h exp=1/00000011", ov2, od2); end
        cyc(); iv2 = 0; #2;
        total++; if (ov2 !== 1'b1 || od2 !== 32'h22) begin bad++; $display("FAIL str_o22 got=%b/%h exp=1/00000022", ov2, od2); end
        cyc(); #2;
        total++; if (ov2 !== 1'b1 || od2 !== 32'h33) begin bad++; $display("FAIL str_o33 got=%b/%h exp=1/00000033", ov2, od2); end
        cyc(); #2;
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL str_empty got=%b exp=0", ov2); end
        cyc();
    endtask

    task automatic test_backpressure();
        or2 = 0; iv2 = 1; id2 = 32'hA; #2;
        total++; if (ir2 !== 1'b1) begin bad++; $display("FAIL bp_rdyA got=%b exp=1", ir2); end
        cyc(); id2 = 32'hB; #2;
        total++; if (ir2 !== 1'b1) begin bad++; $display("FAIL bp_rdyB got=%b exp=1", ir2); end
        cyc(); id2 = 32'hC; #2;
        total++; if (ir2 !== 1'b0) begin bad++; $display("FAIL bp_rdyC got=%b exp=0", ir2); end
`ifdef PIPE_FLOPENR_OCC_EN
        total++; if (occ2 !== 2'd2) begin bad++; $display("FAIL bp_occ got=%0d exp=2", occ2); end
`endif
        cyc(); #2;
        total++; if (ov2 !== 1'b1 || od2 !== 32'hA) begin bad++; $display("FAIL bp_headA got=%b/%h exp=1/0000000a", ov2, od2); end
        or2 = 1; #1;
        total++; if (ir2 !== 1'b1) begin bad++; $display("FAIL bp_fullrdy got=%b exp=1", ir2); end
        cyc(); iv2 = 0; #2;
        total++; if (od2 !== 32'hB) begin bad++; $display("FAIL bp_B got=%h exp=0000000b", od2); end
        cyc(); #2;
        total++; if (ov2 !== 1'b1 || od2 !== 32'hC) begin bad++; $display("FAIL bp_C got=%b/%h exp=1/0000000c", ov2, od2); end
        cyc(); #2;
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", ov2); end
    endtask

    task automatic test_bubble();
        or3 = 0; iv3 = 0; cyc(); cyc();
        iv3 = 1; id3 = 32'h5; #2;
        total++; if (ir3 !== 1'b1) begin bad++; $display("FAIL bub_rdy5 got=%b exp=1", ir3); end
        cyc(); iv3 = 0; cyc(); cyc(); #2;
        total++; if (ov3 !== 1'b1 || od3 !== 32'h5) begin bad++; $display("FAIL bub_tail got=%b/%h exp=1/00000005", ov3, od3); end
        iv3 = 1; id3 = 32'h6; #1;
        total++; if (ir3 !== 1'b1) begin bad++; $display("FAIL bub_rdy6 got=%b exp=1", ir3); end
        cyc(); id3 = 32'h7; #2;
        total++; if (ir3 !== 1'b1) begin bad++; $display("FAIL bub_rdy7 got=%b exp=1", ir3); end
        cyc(); id3 = 32'h8; #2;
        total++; if (ir3 !== 1'b0) begin bad++; $display("FAIL bub_full got=%b exp=0", ir3); end
`ifdef PIPE_FLOPENR_OCC_EN
        total++; if (occ3 !== 2'd3) begin bad++; $display("FAIL bub_occ got=%0d exp=3", occ3); end
`endif
    endtask

    task automatic test_flush();
        fl3 = 1; iv3 = 1; id3 = 32'h77; #1;
        total++; if (ir3 !== 1'b0) begin bad++; $display("FAIL fl_rdy got=%b exp=0", ir3); end
        cyc(); fl3 = 0; iv3 = 0; #2;
        total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL fl_ov got=%b exp=0", ov3); end
`ifdef PIPE_FLOPENR_OCC_EN
        total++; if (occ3 !== 2'd0) begin bad++; $display("FAIL fl_occ got=%0d exp=0", occ3); end
`endif
        or3 = 1;
        for (int k = 0; k < 4; k++) begin
            cyc(); #2;
            total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL fl_ghost%0d got=%b/%h exp=0", k, ov3, od3); end
        end
    endtask

    task automatic test_flush_xfer();
        int n0;
        or2 = 0; iv2 = 1; id2 = 32'h91; cyc();
        id2 = 32'h92; cyc();
        iv2 = 0; #2;
        total++; if (ov2 !== 1'b1 || od2 !== 32'h91) begin bad++; $display("FAIL fx_head got=%b/%h exp=1/00000091", ov2, od2); end
        n0 = nout2;
        or2 = 1; fl2 = 1; cyc();
        fl2 = 0;
        for (int k = 0; k < 3; k++) begin
            #2;
            total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL fx_after%0d got=%b/%h exp=0", k, ov2, od2); end
            cyc();
        end
        total++; if (nout2 - n0 !== 1) begin bad++; $display("FAIL fx_count got=%0d exp=1", nout2 - n0); end
    endtask

    task automatic test_back_to_back();
        int n;
        for (int k = 0; k < 300; k++) begin
            iv3 = 1'($urandom_range(0, 1));
            id3 = $urandom;
            or3 = ($urandom_range(0, 3) != 0);
            fl3 = ($urandom_range(0, 31) == 0);
            cyc();
        end
        iv3 = 0; fl3 = 0; or3 = 1;
        n = 0;
        while (q3.size() != 0 && n < 20) begin cyc(); n++; end
        cyc(); #2;
        total++; if (q3.size() != 0) begin bad++; $display("FAIL b2b_drain got=%0d exp=0 left", q3.size()); end
        total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", ov3); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_flush_xfer();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
